// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, decode constants and the combinational decode function.
// Optional macro ALUCTRL_VARSHIFT_EN enables sllv/srlv/srav decoding.
`default_nettype none

package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       shamt_sel;
    logic       illegal;
  } alu_ctrl_t;

  // Unlisted encodings fall back to AND with illegal set and shamt_sel clear.
  function automatic alu_ctrl_t alu_ctrl_decode_fn(input logic [1:0] aluop,
                                                   input logic [5:0] opcode,
                                                   input logic [5:0] funct);
    alu_ctrl_t r;
    r.ctrl      = ALU_AND;
    r.shamt_sel = 1'b0;
    r.illegal   = 1'b0;
    case (aluop)
      ALUOP_MEM: r.ctrl = ALU_ADD;
      ALUOP_BR:  r.ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD: r.ctrl = ALU_ADD;
          FN_SUB: r.ctrl = ALU_SUB;
          FN_AND: r.ctrl = ALU_AND;
          FN_OR:  r.ctrl = ALU_OR;
          FN_SLT: r.ctrl = ALU_SLT;
          FN_SLL: begin r.ctrl = ALU_SLL; r.shamt_sel = 1'b1; end
          FN_SRL: begin r.ctrl = ALU_SRL; r.shamt_sel = 1'b1; end
          FN_SRA: begin r.ctrl = ALU_SRA; r.shamt_sel = 1'b1; end
`ifdef ALUCTRL_VARSHIFT_EN
          FN_SLLV: r.ctrl = ALU_SLL;
          FN_SRLV: r.ctrl = ALU_SRL;
          FN_SRAV: r.ctrl = ALU_SRA;
`endif
          default: r.illegal = 1'b1;
        endcase
      end
      default: begin
        case (opcode)
          OPC_ADDI: r.ctrl = ALU_ADD;
          OPC_ANDI: r.ctrl = ALU_AND;
          OPC_ORI:  r.ctrl = ALU_OR;
          OPC_SLTI: r.ctrl = ALU_SLT;
          default:  r.illegal = 1'b1;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: generic 2-entry valid/ready skid register (output register + skid register).
// Rev 1.0
`default_nettype none

module alu_skid_buf #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             w_accept;
  logic             w_drain;

  // in_ready comes straight from the skid flag so OutReady never reaches it combinationally.
  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  assign w_accept = in_valid_i && !skid_valid_q;
  assign w_drain  = out_valid_q && out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q) begin
      if (w_accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end
    end else if (w_drain) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_data_d = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: pipelined ALU control decode with valid/ready skid buffering.
// Optional macro ALUCTRL_VARSHIFT_EN (decoded in alu_ctrl_pkg). Rev 1.0
`default_nettype none

module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        ALUOp,
  input  logic [OP_W-1:0]   Opcode,
  input  logic [OP_W-1:0]   Funct,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] ALUCtrlOut,
  output logic              ShamtSel,
  output logic              Illegal
);

  alu_ctrl_t w_dec;
  alu_ctrl_t w_out;

  assign w_dec = alu_ctrl_decode_fn(ALUOp, Opcode, Funct);

  alu_skid_buf #(
    .WIDTH($bits(alu_ctrl_t))
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (InValid),
    .in_ready_o (InReady),
    .in_data_i  (w_dec),
    .out_valid_o(OutValid),
    .out_ready_i(OutReady),
    .out_data_o (w_out)
  );

  assign ALUCtrlOut = w_out.ctrl;
  assign ShamtSel   = w_out.shamt_sel;
  assign Illegal    = w_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: directed and random-stall checks of alu_ctrl_decode.
`default_nettype none

module tb_alu_ctrl_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       OutValid;
  logic       OutReady = 1'b1;
  logic [3:0] ALUCtrlOut;
  logic       ShamtSel;
  logic       Illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_decode #(.CTRL_W(4), .OP_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .InValid   (InValid),
    .InReady   (InReady),
    .ALUOp     (ALUOp),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .ALUCtrlOut(ALUCtrlOut),
    .ShamtSel  (ShamtSel),
    .Illegal   (Illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {ctrl, shamt_sel, illegal}.
  function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [5:0] opc,
                                         input logic [5:0] fn);
    logic [5:0] r;
    r = 6'b0000_0_1;
    if (op == 2'b00) r = 6'b0001_0_0;
    else if (op == 2'b01) r = 6'b0010_0_0;
    else if (op == 2'b10) begin
      if (fn == 6'h20) r = 6'b0001_0_0;
      if (fn == 6'h22) r = 6'b0010_0_0;
      if (fn == 6'h24) r = 6'b0000_0_0;
      if (fn == 6'h25) r = 6'b0011_0_0;
      if (fn == 6'h2A) r = 6'b1001_0_0;
      if (fn == 6'h00) r = 6'b0101_1_0;
      if (fn == 6'h02) r = 6'b0110_1_0;
      if (fn == 6'h03) r = 6'b1000_1_0;
`ifdef ALUCTRL_VARSHIFT_EN
      if (fn == 6'h04) r = 6'b0101_0_0;
      if (fn == 6'h06) r = 6'b0110_0_0;
      if (fn == 6'h07) r = 6'b1000_0_0;
`endif
    end else begin
      if (opc == 6'h08) r = 6'b0001_0_0;
      if (opc == 6'h0C) r = 6'b0000_0_0;
      if (opc == 6'h0D) r = 6'b0011_0_0;
      if (opc == 6'h0A) r = 6'b1001_0_0;
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] opc,
                       input logic [5:0] fn);
    InValid = v;
    ALUOp   = op;
    Opcode  = opc;
    Funct   = fn;
  endtask

  logic [5:0] exp_q[$];
  logic [5:0] fn_tab[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                             6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F};
  logic [5:0] opc_tab[6] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h00};

  initial begin
    int sent, rcvd, cyc;
    logic       stall_prev;
    logic [5:0] prev_out;
    logic [5:0] e;
    localparam int N = 10000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_inready", InReady, 1);
    chk("rst_outputs", {ALUCtrlOut, ShamtSel, Illegal}, 6'b0000_0_0);
    rst_n = 1'b1;

    // Single R-type SUB
    @(negedge clk);
    drive(1, 2'b10, 6'h00, 6'h22);
    @(negedge clk);
    chk("single_valid", OutValid, 1);
    chk("single_out", {ALUCtrlOut, ShamtSel, Illegal}, 6'b0010_0_0);
    drive(0, 2'b00, 6'h00, 6'h00);
    @(negedge clk);
    chk("single_drained", OutValid, 0);

    // Back-to-back stream at full rate
    drive(1, 2'b10, 6'h00, 6'h00);
    @(negedge clk);
    chk("stream_rdy0", InReady, 1);
    chk("stream_sll", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0101_1_0);
    drive(1, 2'b10, 6'h00, 6'h02);
    @(negedge clk);
    chk("stream_rdy1", InReady, 1);
    chk("stream_srl", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0110_1_0);
    drive(1, 2'b10, 6'h00, 6'h03);
    @(negedge clk);
    chk("stream_rdy2", InReady, 1);
    chk("stream_sra", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_1000_1_0);
    drive(1, 2'b10, 6'h00, 6'h2A);
    @(negedge clk);
    chk("stream_rdy3", InReady, 1);
    chk("stream_slt", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_1001_0_0);
    drive(0, 2'b00, 6'h00, 6'h00);
    @(negedge clk);
    chk("stream_end", OutValid, 0);

    // Backpressure: three requests with OutReady low
    OutReady = 1'b0;
    drive(1, 2'b00, 6'h00, 6'h2A);
    @(negedge clk);
    chk("bp_rdy_after1", InReady, 1);
    chk("bp_out1", {OutValid, ALUCtrlOut}, 5'b1_0001);
    drive(1, 2'b01, 6'h00, 6'h00);
    @(negedge clk);
    chk("bp_rdy_after2", InReady, 0);
    chk("bp_hold1", {OutValid, ALUCtrlOut}, 5'b1_0001);
    drive(1, 2'b11, 6'h0D, 6'h00);
    @(negedge clk);
    chk("bp_rdy_full", InReady, 0);
    chk("bp_hold2", {OutValid, ALUCtrlOut}, 5'b1_0001);
    OutReady = 1'b1;
    @(negedge clk);
    chk("bp_out2", {OutValid, ALUCtrlOut}, 5'b1_0010);
    chk("bp_rdy_back", InReady, 1);
    @(negedge clk);
    chk("bp_out3", {OutValid, ALUCtrlOut, Illegal}, 6'b1_0011_0);
    drive(0, 2'b00, 6'h00, 6'h00);
    @(negedge clk);
    chk("bp_empty", OutValid, 0);

    // Illegal encodings and ignored fields
    drive(1, 2'b11, 6'h23, 6'h20);
    @(negedge clk);
    chk("ill_opcode", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0000_0_1);
    drive(1, 2'b10, 6'h08, 6'h04);
    @(negedge clk);
`ifdef ALUCTRL_VARSHIFT_EN
    chk("funct04", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0101_0_0);
`else
    chk("funct04", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0000_0_1);
`endif
    drive(1, 2'b00, 6'h23, 6'h3F);
    @(negedge clk);
    chk("mem_ignores_fields", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0001_0_0);
    drive(1, 2'b10, 6'h3F, 6'h25);
    @(negedge clk);
    chk("rtype_ignores_opc", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, 7'b1_0011_0_0);
    drive(0, 2'b00, 6'h00, 6'h00);
    @(negedge clk);

    // Asynchronous reset with both entries full
    OutReady = 1'b0;
    drive(1, 2'b10, 6'h00, 6'h00);
    @(negedge clk);
    drive(1, 2'b10, 6'h00, 6'h02);
    @(negedge clk);
    chk("pre_rst_full", {InReady, OutValid}, 2'b01);
    drive(0, 2'b00, 6'h00, 6'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outvalid", OutValid, 0);
    chk("async_rst_inready", InReady, 1);
    chk("async_rst_outputs", {ALUCtrlOut, ShamtSel, Illegal}, 6'b0000_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    OutReady = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_stale", {OutValid, ALUCtrlOut}, 5'b0_0000);

    // Random valid/ready stalls against an in-order scoreboard
    sent = 0; rcvd = 0; cyc = 0;
    stall_prev = 1'b0;
    prev_out = '0;
    while (rcvd < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev)
        chk("rand_hold", {OutValid, ALUCtrlOut, ShamtSel, Illegal}, {1'b1, prev_out});
      InValid  = ($urandom_range(0, 3) != 0) && (sent < N);
      ALUOp    = 2'($urandom_range(0, 3));
      Opcode   = ($urandom_range(0, 1) != 0) ? opc_tab[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      Funct    = ($urandom_range(0, 1) != 0) ? fn_tab[$urandom_range(0, 11)] : 6'($urandom_range(0, 63));
      OutReady = ($urandom_range(0, 2) != 0);
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", OutValid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_stream", {ALUCtrlOut, ShamtSel, Illegal}, e);
        end
        rcvd++;
      end
      if (InValid && InReady) begin
        exp_q.push_back(ref_dec(ALUOp, Opcode, Funct));
        sent++;
      end
      stall_prev = OutValid && !OutReady;
      prev_out   = {ALUCtrlOut, ShamtSel, Illegal};
    end
    chk("rand_received", rcvd, N);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Pipelined ALU control stage: decodes the main-control ALUOp plus instruction opcode/funct into the 4-bit ALUCtrlOut code consumed by the ALU. Also produces the A-operand shift-amount select and an illegal flag.
- Sits between the decode stage and the ALU/operand muxes.
- Valid/ready handshake on both sides, 1-cycle latency, 2-entry skid buffer so upstream can stream at full rate under downstream backpressure.

Parameters:
- CTRL_W, 4, width of ALUCtrlOut.
- OP_W, 6, width of opcode and funct fields.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  upstream has a decode request.
- InReady  output  1  stage can accept; transfer when InValid&&InReady.
- ALUOp  input  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- Opcode  input  OP_W  instruction[31:26].
- Funct  input  OP_W  instruction[5:0].
- OutValid  output  1  ALUCtrlOut/ShamtSel/Illegal valid.
- OutReady  input  1  downstream accepts; transfer when OutValid&&OutReady.
- ALUCtrlOut  output  CTRL_W  ALU operation code.
- ShamtSel  output  1  1: operand-A mux selects zero-extended shamt.
- Illegal  output  1  unsupported encoding.

Behaviour:
- Codes: AND 0000, ADD 0001, SUB 0010, OR 0011, SLL 0101, SRL 0110, SRA 1000, SLT 1001.
- ALUOp decoding:
  - 00 -> ADD.
  - 01 -> SUB.
  - 10 -> by Funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - 11 -> by Opcode: 0x08 ADD (addi), 0x0C AND (andi), 0x0D OR (ori), 0x0A SLT (slti).
  - Funct is ignored unless ALUOp=10; Opcode is ignored unless ALUOp=11.
- ShamtSel=1 only for SLL/SRL/SRA from funct 0x00/0x02/0x03; 0 otherwise.
- Any unlisted encoding: ALUCtrlOut=0000, ShamtSel=0, Illegal=1. Illegal results still flow through the handshake like normal results.
- Decode is combinational on the input. The result is registered into the output register, giving 1-cycle latency from accept to OutValid.
- Skid buffer: output register plus one skid register.
  - InReady = !skid_full, a registered signal with no combinational path from OutReady.
  - Accept while the output register is full and not draining -> the result goes to the skid register.
  - When the output drains and the skid is full -> skid moves to output, skid clears.
  - Ordering is strictly FIFO.
- Simultaneous accept and drain with the skid empty: the new result replaces the output, OutValid stays 1, and the skid stays empty.
- Both entries full and OutReady=0: InReady=0, and all outputs are held stable.
- Throughput: 1 result/cycle when OutReady=1 continuously.
- Outputs hold their value while OutValid&&!OutReady (no change allowed).
- Reset (asynchronous, any time, including mid-stream):
  - OutValid=0, InReady=1 after reset, skid empty.
  - ALUCtrlOut=0000, ShamtSel=0, Illegal=0.
  - In-flight entries are discarded.

Optional Feature:
- Macro ALUCTRL_VARSHIFT_EN.
- Defined: ALUOp=10 additionally decodes funct 0x04 -> SLL, 0x06 -> SRL, 0x07 -> SRA (sllv/srlv/srav) with ShamtSel=0, so A comes from rs.
- Undefined: those funct values are Illegal (ALUCtrlOut=0000).

Decomposition:
- Package alu_ctrl_pkg holds:
  - localparams for the eight ALU op codes;
  - ALUOp class constants;
  - opcode/funct constants;
  - packed struct alu_ctrl_t {ctrl[3:0], shamt_sel, illegal}.
- Decode is a combinational function in the package.
- Sub-module alu_skid_buf (parameter WIDTH) implements the generic 2-entry valid/ready skid register. alu_ctrl_decode instantiates it with WIDTH=$bits(alu_ctrl_t).

Test Plan:
- Reset then single R-type: ALUOp=10, Funct=0x22, OutReady=1 -> next cycle OutValid=1, ALUCtrlOut=0010, ShamtSel=0, Illegal=0.
- Stream ALUOp=10 with Funct 0x00, 0x02, 0x03, 0x2A back-to-back, OutReady=1 -> outputs 0101/1, 0110/1, 1000/1, 1001/0 on consecutive cycles, InReady always 1.
- Backpressure:
  - Hold OutReady=0 and present 3 requests (ALUOp 00, 01, 11/Opcode 0x0D) -> InReady drops to 0 after the 2nd accept.
  - Release OutReady -> outputs 0001, 0010, 0011 in order, nothing lost or duplicated.
- Illegal: ALUOp=11, Opcode=0x23 -> ALUCtrlOut=0000, Illegal=1. ALUOp=10, Funct=0x04 -> Illegal=1 without ALUCTRL_VARSHIFT_EN; 0101 with ShamtSel=0 with it.
- Async reset mid-stream with both entries full -> OutValid=0 and InReady=1 immediately on rst_n low, no stale output after release.
- Random valid/ready stall pattern, 10k transactions -> scoreboard matches the package decode function in order; outputs stable while stalled.
